// File: rtl/fsm_slave.sv
// fsm_slave: slave-side control FSM for the thermostat link.
// Sequences the receive FIFO: "mem" stores one UART byte then clears the
// receiver; "leg" drains the FIFO until empty.
// Optional build macro FSM_TIMEOUT_EN adds a watchdog on MEM and LEG that
// returns to IDLE after TIMEOUT_CYCLES cycles without the exit condition.
module fsm_slave #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STATE_W        = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mem,
    input  logic leg,
    input  logic empty,
    input  logic o_RX_DV,
    output logic clear,
    output logic insert,
    output logic remove
);

    typedef enum logic [STATE_W-1:0] {
        IDLE  = STATE_W'(0),
        MEM   = STATE_W'(1),
        CLEAR = STATE_W'(2),
        LEG   = STATE_W'(3)
    } state_t;

    state_t state, state_nxt;
    logic   clear_c, insert_c, remove_c;
    logic   timeout;

`ifdef FSM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt;

    // Watchdog: held at zero outside MEM/LEG so it starts from zero on entry.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (state == MEM || state == LEG)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register; reset forces IDLE.
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and Mealy outputs; a normal exit beats the watchdog.
    always_comb begin
        state_nxt = IDLE;
        clear_c   = 1'b0;
        insert_c  = 1'b0;
        remove_c  = 1'b0;
        case (state)
            IDLE: begin
                if (mem)
                    state_nxt = MEM;
                else if (leg)
                    state_nxt = LEG;
                else
                    state_nxt = IDLE;
            end
            MEM: begin
                insert_c = o_RX_DV;
                if (o_RX_DV)
                    state_nxt = CLEAR;
                else if (timeout)
                    state_nxt = IDLE;
                else
                    state_nxt = MEM;
            end
            CLEAR: begin
                clear_c   = 1'b1;
                state_nxt = IDLE;
            end
            LEG: begin
                remove_c = ~empty;
                if (empty || timeout)
                    state_nxt = IDLE;
                else
                    state_nxt = LEG;
            end
            default: begin
                // Unused encodings (only possible with wider STATE_W) recover.
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are suppressed while reset is held so nothing leaks mid-reset.
    assign clear  = rst & clear_c;
    assign insert = rst & insert_c;
    assign remove = rst & remove_c;

endmodule

// File: tb/tb_fsm_slave.sv
// tb_fsm_slave: directed test of fsm_slave (reset, store, read, priority,
// reset mid-operation, watchdog or indefinite wait depending on build).
module tb_fsm_slave;

    logic clk = 1'b0;
    logic rst, mem, leg, empty, o_RX_DV;
    logic clear, insert, remove;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_MEM = 2'd1, S_CLEAR = 2'd2, S_LEG = 2'd3;

    fsm_slave #(.TIMEOUT_CYCLES(16), .STATE_W(2)) dut (
        .clk(clk), .rst(rst), .mem(mem), .leg(leg), .empty(empty),
        .o_RX_DV(o_RX_DV), .clear(clear), .insert(insert), .remove(remove)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp = {clear, insert, remove}
    task automatic chk_out(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        #1;
        obs = {clear, insert, remove};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: {clear,insert,remove} got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [1:0] exp);
        logic [1:0] obs;
        obs = dut.state;
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: state got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; mem = 1'b0; leg = 1'b0; empty = 1'b0; o_RX_DV = 1'b0;
        tick();

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            {mem, leg, empty, o_RX_DV} = 4'($urandom_range(0, 15));
            chk_out("rst_out", 3'b000);
            tick();
            chk_st("rst_state", S_IDLE);
        end

        // Released, idle with no command
        rst = 1'b1; mem = 1'b0; leg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {empty, o_RX_DV} = 2'(i);
            chk_out("idle_out", 3'b000);
            tick();
            chk_st("idle_state", S_IDLE);
        end
        empty = 1'b0; o_RX_DV = 1'b0;

        // Store path
        mem = 1'b1;
        chk_out("mem_cmd_out", 3'b000);
        tick();
        chk_st("mem_enter", S_MEM);
        for (int i = 0; i < 8; i++) begin
            {mem, leg, empty} = 3'(i);
            o_RX_DV = 1'b0;
            chk_out("mem_wait_out", 3'b000);
            tick();
            chk_st("mem_wait_state", S_MEM);
        end
        mem = 1'b0; leg = 1'b0; empty = 1'b0; o_RX_DV = 1'b1;
        chk_out("mem_insert", 3'b010);
        tick();
        chk_st("clear_state", S_CLEAR);
        o_RX_DV = 1'b0;
        chk_out("clear_pulse", 3'b100);
        tick();
        chk_st("after_clear", S_IDLE);
        chk_out("after_clear_out", 3'b000);

        // Read path
        leg = 1'b1; empty = 1'b0;
        tick();
        chk_st("leg_enter", S_LEG);
        for (int i = 0; i < 8; i++) begin
            {mem, leg, o_RX_DV} = 3'(i);
            empty = 1'b0;
            chk_out("leg_remove", 3'b001);
            tick();
            chk_st("leg_stay", S_LEG);
        end
        mem = 1'b0; leg = 1'b0; o_RX_DV = 1'b0; empty = 1'b1;
        chk_out("leg_empty_out", 3'b000);
        tick();
        chk_st("leg_exit", S_IDLE);
        empty = 1'b0;

        // Priority: mem beats leg
        mem = 1'b1; leg = 1'b1;
        tick();
        chk_st("prio_state", S_MEM);
        mem = 1'b0; leg = 1'b0; o_RX_DV = 1'b1;
        chk_out("prio_insert", 3'b010);
        tick();
        chk_st("prio_clear", S_CLEAR);
        o_RX_DV = 1'b0;
        tick();
        chk_st("prio_idle", S_IDLE);

        // Reset mid-LEG
        leg = 1'b1; empty = 1'b0;
        tick();
        chk_st("midrst_leg_enter", S_LEG);
        leg = 1'b0;
        chk_out("midrst_leg_pre", 3'b001);
        rst = 1'b0;
        chk_out("midrst_leg_out", 3'b000);
        tick();
        chk_st("midrst_leg_state", S_IDLE);
        rst = 1'b1;

        // Reset mid-MEM with o_RX_DV pending
        mem = 1'b1;
        tick();
        chk_st("midrst_mem_enter", S_MEM);
        mem = 1'b0; o_RX_DV = 1'b1;
        chk_out("midrst_mem_pre", 3'b010);
        rst = 1'b0;
        chk_out("midrst_mem_out", 3'b000);
        tick();
        chk_st("midrst_mem_state", S_IDLE);
        rst = 1'b1; o_RX_DV = 1'b0;
        chk_out("midrst_mem_post", 3'b000);
        tick();
        chk_st("midrst_mem_idle", S_IDLE);

`ifdef FSM_TIMEOUT_EN
        // Watchdog: 16 cycles in MEM then IDLE with no insert/clear
        mem = 1'b1;
        tick();
        mem = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_st("to_mem_state", S_MEM);
            chk_out("to_mem_out", 3'b000);
            tick();
        end
        chk_st("to_mem_idle", S_IDLE);
        chk_out("to_mem_idle_out", 3'b000);

        // Watchdog in LEG with FIFO never empty
        leg = 1'b1; empty = 1'b0;
        tick();
        leg = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_st("to_leg_state", S_LEG);
            chk_out("to_leg_out", 3'b001);
            tick();
        end
        chk_st("to_leg_idle", S_IDLE);
        chk_out("to_leg_idle_out", 3'b000);
`else
        // No watchdog: MEM and LEG wait well past 16 cycles
        mem = 1'b1;
        tick();
        mem = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk_st("wait_mem_state", S_MEM);
        o_RX_DV = 1'b1;
        chk_out("wait_mem_insert", 3'b010);
        tick();
        o_RX_DV = 1'b0;
        chk_st("wait_mem_clear", S_CLEAR);
        tick();
        chk_st("wait_mem_idle", S_IDLE);

        leg = 1'b1; empty = 1'b0;
        tick();
        leg = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk_st("wait_leg_state", S_LEG);
        chk_out("wait_leg_remove", 3'b001);
        empty = 1'b1;
        tick();
        chk_st("wait_leg_idle", S_IDLE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
